// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: chunk-order encodings,
// the shift-register update selector and the level-width helper.
package word_serializer_pkg;

    // Chunk emission order encodings for the MSB_FIRST parameter
    localparam int SER_LSB_FIRST = 0;
    localparam int SER_MSB_FIRST = 1;

    // What happens to the shift register on the coming edge
    typedef enum logic [2:0] {
        UPD_HOLD  = 3'd0,   // nothing moves
        UPD_SHIFT = 3'd1,   // emit one chunk, word still has more
        UPD_SLOT  = 3'd2,   // last chunk emitted, refill from prefetch slot
        UPD_IN    = 3'd3,   // load straight from the input port
        UPD_DONE  = 3'd4    // last chunk emitted, nothing waiting
    } sh_upd_e;

    // Width of the level counter: holds 0 .. 2*nchunk
    function automatic int cnt_width(input int nchunk);
        return $clog2(2 * nchunk + 1);
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / chunk-out handshake bundle. slave = serializer side,
// master = the producer/consumer environment around it.
interface word_serializer_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_first;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_first, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_last
    );
endinterface

// File: rtl/word_buf_slot.sv
// One-entry prefetch buffer. load captures a word and marks it valid,
// take releases it. The parent never loads and takes on the same edge.
module word_buf_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         v
);

    logic [W-1:0] data_q, data_d;
    logic         v_q, v_d;

    // Next-state: capture on load, clear valid on take
    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        if (take) begin
            v_d = 1'b0;
        end
        if (load) begin
            data_d = load_data;
            v_d    = 1'b1;
        end
    end

    // Slot registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign data = data_q;
    assign v    = v_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial width converter: IN_W-bit words in, OUT_W-bit chunks
// out, with a one-word prefetch slot so back-to-back words stream without
// bubbles while the shift register drains.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 2,
    parameter int MSB_FIRST = SER_LSB_FIRST,
    parameter int NEAR_TH   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    word_serializer_if.slave                     bus,
    output logic                                 empty,
    output logic                                 near_empty,
    output logic [cnt_width(IN_W/OUT_W)-1:0]     level
);

    localparam int NCHUNK = IN_W / OUT_W;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam int REM_W  = $clog2(NCHUNK + 1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(NCHUNK);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [REM_W-1:0] REM_ZERO = '0;

    // Reject geometries that cannot be split into at least two whole chunks
    if ((IN_W % OUT_W) != 0 || (IN_W / OUT_W) < 2) begin : g_bad_width
        $error("word_serializer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end
    if (NEAR_TH < 1 || NEAR_TH > (IN_W / OUT_W)) begin : g_bad_near
        $error("word_serializer: NEAR_TH must lie in 1..IN_W/OUT_W");
    end

    // Chunk currently presented by a word, depending on emission order
    function automatic logic [OUT_W-1:0] head_chunk(input logic [IN_W-1:0] w);
        if (MSB_FIRST == SER_MSB_FIRST) begin
            return w[IN_W-1 -: OUT_W];
        end else begin
            return w[OUT_W-1:0];
        end
    endfunction

    // Word after the head chunk has been consumed (zero fill behind it)
    function automatic logic [IN_W-1:0] drop_chunk(input logic [IN_W-1:0] w);
        if (MSB_FIRST == SER_MSB_FIRST) begin
            return w << OUT_W;
        end else begin
            return w >> OUT_W;
        end
    endfunction

    logic [IN_W-1:0]  sh_q, sh_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [IN_W-1:0]  slot_data;
    logic             slot_v;
    logic             slot_load;
    logic             slot_take;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;
    logic             in_to_sh;
    sh_upd_e          upd;

    // Prefetch slot holding the next word while the current one drains
    word_buf_slot #(
        .W (IN_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .take      (slot_take),
        .load_data (bus.in_data),
        .data      (slot_data),
        .v         (slot_v)
    );

    assign in_ready  = en && !slot_v;
    assign out_valid = en && (rem_q != REM_ZERO);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid && bus.out_ready;

    // Decide the shift-register action; an accepted word goes to the shift
    // register only when it would otherwise sit idle, else into the slot
    always_comb begin
        upd       = UPD_HOLD;
        slot_take = 1'b0;
        in_to_sh  = 1'b0;
        if (out_fire && (rem_q > REM_ONE)) begin
            upd = UPD_SHIFT;
        end else if (out_fire) begin
            if (slot_v) begin
                upd       = UPD_SLOT;
                slot_take = 1'b1;
            end else if (in_fire) begin
                upd      = UPD_IN;
                in_to_sh = 1'b1;
            end else begin
                upd = UPD_DONE;
            end
        end else if ((rem_q == REM_ZERO) && in_fire) begin
            upd      = UPD_IN;
            in_to_sh = 1'b1;
        end
        slot_load = in_fire && !in_to_sh;
    end

    // Apply the chosen action to the shift register and chunk counter
    always_comb begin
        sh_d  = sh_q;
        rem_d = rem_q;
        case (upd)
            UPD_SHIFT: begin
                sh_d  = drop_chunk(sh_q);
                rem_d = rem_q - REM_ONE;
            end
            UPD_SLOT: begin
                sh_d  = slot_data;
                rem_d = REM_FULL;
            end
            UPD_IN: begin
                sh_d  = bus.in_data;
                rem_d = REM_FULL;
            end
            UPD_DONE: begin
                rem_d = REM_ZERO;
            end
            default: begin
                sh_d  = sh_q;
                rem_d = rem_q;
            end
        endcase
    end

    // Shift register and remaining-chunk counter, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            rem_q <= REM_ZERO;
        end else begin
            sh_q  <= sh_d;
            rem_q <= rem_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_chunk(sh_q);
    assign bus.out_first = (rem_q == REM_FULL);
    assign bus.out_last  = (rem_q == REM_ONE);

    assign empty      = (rem_q == REM_ZERO) && !slot_v;
    assign level      = CNT_W'(rem_q) + (slot_v ? CNT_W'(NCHUNK) : CNT_W'(0));
    assign near_empty = !empty && (level <= CNT_W'(NEAR_TH));

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one LSB-first and one MSB-first
// instance share all stimulus; outputs are sampled on the falling edge.
module tb_word_serializer;
    import word_serializer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        empty_l, near_l, empty_m, near_m;
    logic [5:0]  level_l, level_m;

    int n_cmp = 0;
    int n_err = 0;

    // sampled view of the instance under inspection
    logic       s_valid, s_ready, s_first, s_last, s_empty, s_near;
    logic [1:0] s_data;
    logic [5:0] s_level;

    word_serializer_if #(.IN_W(32), .OUT_W(2)) bus_l ();
    word_serializer_if #(.IN_W(32), .OUT_W(2)) bus_m ();

    assign bus_l.in_valid  = in_valid;
    assign bus_l.in_data   = in_data;
    assign bus_l.out_ready = out_ready;
    assign bus_m.in_valid  = in_valid;
    assign bus_m.in_data   = in_data;
    assign bus_m.out_ready = out_ready;

    word_serializer #(.IN_W(32), .OUT_W(2), .MSB_FIRST(SER_LSB_FIRST), .NEAR_TH(2)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .bus(bus_l.slave),
        .empty(empty_l), .near_empty(near_l), .level(level_l)
    );

    word_serializer #(.IN_W(32), .OUT_W(2), .MSB_FIRST(SER_MSB_FIRST), .NEAR_TH(2)) u_msb (
        .clk(clk), .rst(rst), .en(en), .bus(bus_m.slave),
        .empty(empty_m), .near_empty(near_m), .level(level_m)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit msb);
        if (msb) begin
            s_valid = bus_m.out_valid; s_ready = bus_m.in_ready; s_data = bus_m.out_data;
            s_first = bus_m.out_first; s_last = bus_m.out_last;
            s_empty = empty_m; s_near = near_m; s_level = level_m;
        end else begin
            s_valid = bus_l.out_valid; s_ready = bus_l.in_ready; s_data = bus_l.out_data;
            s_first = bus_l.out_first; s_last = bus_l.out_last;
            s_empty = empty_l; s_near = near_l; s_level = level_l;
        end
    endtask

    function automatic logic [1:0] exp_chunk(input logic [31:0] w, input int i, input bit msb);
        logic [31:0] t;
        t = msb ? (w >> (30 - 2 * i)) : (w >> (2 * i));
        return t[1:0];
    endfunction

    // Present a word at the falling edge and hold it until accepted
    task automatic send_word(input string tag, input logic [31:0] w);
        int cnt;
        in_data  = w;
        in_valid = 1'b1;
        cnt = 0;
        while (!bus_l.in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) chk({tag, "_accept_timeout"}, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("%s: sent word %08h after %0d wait cycles", tag, w, cnt);
    endtask

    // Check all 16 chunks of a word; optionally stall at one chunk either
    // by withholding out_ready or by dropping en
    task automatic drain_word(input string tag, input logic [31:0] w, input bit msb,
                              input int hold_at, input int hold_len, input bit hold_by_en);
        for (int i = 0; i < 16; i++) begin
            sample(msb);
            chk($sformatf("%s_valid%0d", tag, i), s_valid, 1);
            chk($sformatf("%s_data%0d", tag, i), s_data, exp_chunk(w, i, msb));
            chk($sformatf("%s_first%0d", tag, i), s_first, (i == 0));
            chk($sformatf("%s_last%0d", tag, i), s_last, (i == 15));
            chk($sformatf("%s_level%0d", tag, i), s_level, 16 - i);
            chk($sformatf("%s_near%0d", tag, i), s_near, ((16 - i) <= 2));
            chk($sformatf("%s_empty%0d", tag, i), s_empty, 0);
            if (i == hold_at) begin
                if (hold_by_en) en = 1'b0; else out_ready = 1'b0;
                for (int k = 0; k < hold_len; k++) begin
                    @(negedge clk);
                    sample(msb);
                    chk($sformatf("%s_hold_data%0d", tag, k), s_data, exp_chunk(w, i, msb));
                    chk($sformatf("%s_hold_level%0d", tag, k), s_level, 16 - i);
                    chk($sformatf("%s_hold_valid%0d", tag, k), s_valid, !hold_by_en);
                    if (hold_by_en) chk($sformatf("%s_hold_inrdy%0d", tag, k), s_ready, 0);
                end
                en = 1'b1;
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        sample(msb);
        chk({tag, "_end_valid"}, s_valid, 0);
        chk({tag, "_end_empty"}, s_empty, 1);
        chk({tag, "_end_level"}, s_level, 0);
        chk({tag, "_end_near"}, s_near, 0);
        $display("%s: drained word %08h (msb_first=%0d)", tag, w, msb);
    endtask

    logic [31:0] stream_w [3];

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stream_w[0] = 32'h1234_5678;
        stream_w[1] = 32'h9ABC_DEF0;
        stream_w[2] = 32'h0F1E_2D3C;
        repeat (2) @(negedge clk);

        // reset state
        sample(0);
        chk("rst_valid", s_valid, 0);
        chk("rst_data", s_data, 0);
        chk("rst_first", s_first, 0);
        chk("rst_last", s_last, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_near", s_near, 0);
        chk("rst_level", s_level, 0);
        chk("rst_inrdy", s_ready, 1);
        $display("reset: state checked");
        rst = 1'b0;
        @(negedge clk);

        // T1: LSB-first single word
        out_ready = 1'b1;
        send_word("t1", 32'h8000_0001);
        drain_word("t1", 32'h8000_0001, 0, -1, 0, 0);

        // T2: MSB-first single word
        send_word("t2", 32'hC000_0003);
        drain_word("t2", 32'hC000_0003, 1, -1, 0, 0);

        // T3: three back-to-back words, gap-free
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int cnt;
                    in_data  = stream_w[k];
                    in_valid = 1'b1;
                    cnt = 0;
                    while (!bus_l.in_ready && cnt < 100) begin
                        @(negedge clk);
                        cnt++;
                    end
                    if (cnt >= 100) chk("t3_accept_timeout", 0, 1);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                int cnt;
                cnt = 0;
                while (!bus_l.out_valid && cnt < 100) begin
                    @(negedge clk);
                    cnt++;
                end
                if (cnt >= 100) chk("t3_start_timeout", 0, 1);
                for (int j = 0; j < 48; j++) begin
                    sample(0);
                    chk($sformatf("t3_valid%0d", j), s_valid, 1);
                    chk($sformatf("t3_data%0d", j), s_data, exp_chunk(stream_w[j / 16], j % 16, 0));
                    chk($sformatf("t3_first%0d", j), s_first, ((j % 16) == 0));
                    chk($sformatf("t3_inrdy%0d", j), s_ready, ((j % 16) == 0) || (j > 32));
                    @(negedge clk);
                end
                sample(0);
                chk("t3_end_valid", s_valid, 0);
                chk("t3_end_empty", s_empty, 1);
            end
        join
        $display("t3: streamed 3 words");

        // T4: backpressure for 3 cycles at chunk 5
        send_word("t4", 32'hE4E4_E4E4);
        drain_word("t4", 32'hE4E4_E4E4, 0, 5, 3, 0);

        // T5: near_empty tail and en stall for 4 cycles at chunk 9
        send_word("t5", 32'h0000_FFFF);
        drain_word("t5", 32'h0000_FFFF, 0, 9, 4, 1);

        // T6: asynchronous reset at chunk 7 with the slot full
        out_ready = 1'b0;
        send_word("t6a", 32'hAAAA_5555);
        send_word("t6b", 32'h3333_CCCC);
        sample(0);
        chk("t6_full_level", s_level, 32);
        chk("t6_full_inrdy", s_ready, 0);
        out_ready = 1'b1;
        repeat (7) @(negedge clk);
        sample(0);
        chk("t6_chunk7_data", s_data, exp_chunk(32'hAAAA_5555, 7, 0));
        chk("t6_chunk7_level", s_level, 25);
        #2 rst = 1'b1;
        #1;
        sample(0);
        chk("t6_rst_valid", s_valid, 0);
        chk("t6_rst_empty", s_empty, 1);
        chk("t6_rst_level", s_level, 0);
        chk("t6_rst_data", s_data, 0);
        chk("t6_rst_inrdy", s_ready, 1);
        $display("t6: reset applied mid-word");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word("t6c", 32'h0123_4567);
        drain_word("t6c", 32'h0123_4567, 0, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
